// File: rtl/alu_issue.sv
// alu_issue: two-entry in-order issue buffer that decodes ALUOp/funct into a 3-bit ALU code at push.
// Optional feature: define ALU_ISSUE_MUL_EN to accept funct 011000 as a legal multiply (code 100).
module alu_issue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       ALUOp_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] data1_o,
  output logic [WIDTH-1:0] data2_o,
  output logic [2:0]       ALUControl_o,
  output logic             illegal_o,
  output logic [7:0]       illegal_cnt_o
);

  localparam logic [1:0] FULL_OCC = 2'(DEPTH);

  // Result packs {illegal_flag, alu_code}.
  function automatic logic [3:0] decode_op(input logic [1:0] alu_op, input logic [5:0] funct);
    logic [3:0] res;
    res = 4'b0_000;
    case (alu_op)
      2'b00: res = 4'b0_010;
      2'b01: res = 4'b0_110;
      2'b11: res = 4'b0_001;
      2'b10: begin
        case (funct)
          6'b100000: res = 4'b0_010;
          6'b100010: res = 4'b0_110;
          6'b100100: res = 4'b0_000;
          6'b100101: res = 4'b0_001;
          6'b101010: res = 4'b0_111;
`ifdef ALU_ISSUE_MUL_EN
          6'b011000: res = 4'b0_100;
`else
          6'b011000: res = 4'b1_000;
`endif
          default:   res = 4'b1_000;
        endcase
      end
      default: res = 4'b0_000;
    endcase
    return res;
  endfunction

  logic [WIDTH-1:0] d1_q   [DEPTH];
  logic [WIDTH-1:0] d1_d   [DEPTH];
  logic [WIDTH-1:0] d2_q   [DEPTH];
  logic [WIDTH-1:0] d2_d   [DEPTH];
  logic [2:0]       ctrl_q [DEPTH];
  logic [2:0]       ctrl_d [DEPTH];
  logic             ill_q  [DEPTH];
  logic             ill_d  [DEPTH];
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [1:0]       occ_q, occ_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [3:0]       dec_s;
  logic             push_s;
  logic             pop_s;

  // rst_i term keeps ready low during reset even though occupancy is already 0.
  assign in_ready_o    = rst_i && (occ_q < FULL_OCC);
  assign out_valid_o   = (occ_q != 2'd0);
  assign push_s        = in_valid_i && in_ready_o;
  assign pop_s         = out_valid_o && out_ready_i;
  assign data1_o       = out_valid_o ? d1_q[head_q]   : {WIDTH{1'b0}};
  assign data2_o       = out_valid_o ? d2_q[head_q]   : {WIDTH{1'b0}};
  assign ALUControl_o  = out_valid_o ? ctrl_q[head_q] : 3'b000;
  assign illegal_o     = out_valid_o ? ill_q[head_q]  : 1'b0;
  assign illegal_cnt_o = cnt_q;

  // Next-state: write tail on push, advance head on pop, track occupancy and illegal count.
  always_comb begin
    d1_d   = d1_q;
    d2_d   = d2_q;
    ctrl_d = ctrl_q;
    ill_d  = ill_q;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    cnt_d  = cnt_q;
    dec_s  = decode_op(ALUOp_i, funct_i);
    if (push_s) begin
      d1_d[tail_q]   = data1_i;
      d2_d[tail_q]   = data2_i;
      ctrl_d[tail_q] = dec_s[2:0];
      ill_d[tail_q]  = dec_s[3];
      tail_d         = ~tail_q;
      if (dec_s[3] && (cnt_q != 8'hFF)) begin
        cnt_d = cnt_q + 8'd1;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      tail_d = tail_q;
    end
    if (pop_s) begin
      head_d = ~head_q;
    end else begin
      head_d = head_q;
    end
    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // State registers; reset discards any buffered entries.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        d1_q[i]   <= {WIDTH{1'b0}};
        d2_q[i]   <= {WIDTH{1'b0}};
        ctrl_q[i] <= 3'b000;
        ill_q[i]  <= 1'b0;
      end
      head_q <= 1'b0;
      tail_q <= 1'b0;
      occ_q  <= 2'd0;
      cnt_q  <= 8'd0;
    end else begin
      d1_q   <= d1_d;
      d2_q   <= d2_d;
      ctrl_q <= ctrl_d;
      ill_q  <= ill_d;
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: scoreboard bench for alu_issue; expected entries queued at push, compared at pop.
module tb_alu_issue;
  localparam int WIDTH = 32;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic [1:0]       ALUOp_i = 2'b00;
  logic [5:0]       funct_i = 6'b000000;
  logic [WIDTH-1:0] data1_i = '0;
  logic [WIDTH-1:0] data2_i = '0;
  logic             out_valid_o;
  logic             out_ready_i = 1'b0;
  logic [WIDTH-1:0] data1_o;
  logic [WIDTH-1:0] data2_o;
  logic [2:0]       ALUControl_o;
  logic             illegal_o;
  logic [7:0]       illegal_cnt_o;

  always #5 clk_i = ~clk_i;

  alu_issue #(.WIDTH(WIDTH), .DEPTH(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .ALUOp_i(ALUOp_i), .funct_i(funct_i), .data1_i(data1_i), .data2_i(data2_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .data1_o(data1_o), .data2_o(data2_o),
    .ALUControl_o(ALUControl_o), .illegal_o(illegal_o), .illegal_cnt_o(illegal_cnt_o)
  );

  typedef struct packed {
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [2:0]       ctrl;
    logic             ill;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [3:0] mon_dec;
  int         checks = 0;
  int         failures = 0;
  int         pops = 0;
  int         cyc = 0;
  int         ill_model = 0;
  logic       rand_rdy = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode, returns {illegal, code}.
  function automatic logic [3:0] ref_decode(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'b00) return 4'h2;
    if (op == 2'b01) return 4'h6;
    if (op == 2'b11) return 4'h1;
    case (fn)
      6'h20: return 4'h2;
      6'h22: return 4'h6;
      6'h24: return 4'h0;
      6'h25: return 4'h1;
      6'h2A: return 4'h7;
`ifdef ALU_ISSUE_MUL_EN
      6'h18: return 4'h4;
`else
      6'h18: return 4'h8;
`endif
      default: return 4'h8;
    endcase
  endfunction

  always @(posedge clk_i) cyc <= cyc + 1;

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      sb_q.delete();
      ill_model = 0;
      check_eq("rst_out_valid", out_valid_o, 0);
      check_eq("rst_in_ready", in_ready_o, 0);
      check_eq("rst_data1", data1_o, 0);
      check_eq("rst_ctrl", ALUControl_o, 0);
      check_eq("rst_illegal", illegal_o, 0);
      check_eq("rst_ill_cnt", illegal_cnt_o, 0);
    end else begin
      check_eq("out_valid", out_valid_o, sb_q.size() != 0);
      check_eq("in_ready", in_ready_o, sb_q.size() < 2);
      check_eq("ill_cnt", illegal_cnt_o, ill_model);
      if (sb_q.size() == 0) begin
        check_eq("empty_data1", data1_o, 0);
        check_eq("empty_data2", data2_o, 0);
        check_eq("empty_ctrl", ALUControl_o, 0);
        check_eq("empty_illegal", illegal_o, 0);
      end else begin
        mon_e = sb_q[0];
        check_eq("head_data1", data1_o, mon_e.d1);
        check_eq("head_data2", data2_o, mon_e.d2);
        check_eq("head_ctrl", ALUControl_o, mon_e.ctrl);
        check_eq("head_illegal", illegal_o, mon_e.ill);
        if (out_ready_i) begin
          void'(sb_q.pop_front());
          pops++;
        end
      end
      if (in_valid_i && in_ready_o) begin
        mon_dec   = ref_decode(ALUOp_i, funct_i);
        mon_e.d1   = data1_i;
        mon_e.d2   = data2_i;
        mon_e.ctrl = mon_dec[2:0];
        mon_e.ill  = mon_dec[3];
        sb_q.push_back(mon_e);
        if (mon_dec[3] && ill_model < 255) ill_model++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic push_op(input logic [1:0] op, input logic [5:0] fn,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int   waited;
    logic acc;
    ALUOp_i = op; funct_i = fn; data1_i = a; data2_i = b; in_valid_i = 1'b1;
    waited = 0;
    acc = 1'b0;
    while (!acc && waited < 50) begin
      @(negedge clk_i);
      acc = in_ready_o;
      @(posedge clk_i);
      #1;
      if (!acc) begin
        waited++;
        if (rand_rdy) out_ready_i = 1'($urandom_range(0, 1));
      end
    end
    in_valid_i = 1'b0;
    check_eq("push_accept", acc, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    int c0;
    logic [5:0] fn_tab [8];
    fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18, 6'h00, 6'h3F};

    idle(3);
    check_eq("reset_in_ready", in_ready_o, 0);
    check_eq("reset_out_valid", out_valid_o, 0);
    check_eq("reset_ill_cnt", illegal_cnt_o, 0);
    rst_i = 1'b1;

    // First op: add, one-cycle latency, no combinational path.
    ALUOp_i = 2'b10; funct_i = 6'b100000; data1_i = 32'd5; data2_i = 32'd7; in_valid_i = 1'b1;
    #1;
    check_eq("first_no_comb", out_valid_o, 0);
    check_eq("first_ready", in_ready_o, 1);
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    check_eq("first_valid", out_valid_o, 1);
    check_eq("first_ctrl", ALUControl_o, 3'b010);
    check_eq("first_d1", data1_o, 32'd5);
    check_eq("first_d2", data2_o, 32'd7);
    out_ready_i = 1'b1;
    idle(2);

    // Backpressure: fill, hold third, release.
    out_ready_i = 1'b0;
    p0 = pops;
    push_op(2'b00, 6'h00, 32'd11, 32'd12);
    push_op(2'b01, 6'h00, 32'd21, 32'd22);
    check_eq("full_ready", in_ready_o, 0);
    ALUOp_i = 2'b11; data1_i = 32'd31; data2_i = 32'd32; in_valid_i = 1'b1;
    idle(3);
    check_eq("full_hold_ready", in_ready_o, 0);
    check_eq("full_hold_pops", pops, p0);
    out_ready_i = 1'b1;
    push_op(2'b11, 6'h00, 32'd31, 32'd32);
    idle(4);
    check_eq("bp_pops", pops, p0 + 3);

    // Random traffic with random backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int idx;
      logic [5:0] fn;
      idx = $urandom_range(0, 7);
      fn = fn_tab[idx];
      if (idx == 7) fn = 6'($urandom);
      out_ready_i = 1'($urandom_range(0, 1));
      push_op(2'($urandom), fn, $urandom, $urandom);
    end
    rand_rdy = 1'b0;
    out_ready_i = 1'b1;
    idle(4);

    // Streaming at occupancy 1: one op per cycle.
    push_op(2'b00, 6'h00, 32'd100, 32'd200);
    c0 = cyc;
    p0 = pops;
    for (int i = 0; i < 20; i++) begin
      push_op(2'b10, fn_tab[i % 5], 32'(i), 32'(i * 3));
    end
    check_eq("stream_cycles", cyc - c0, 20);
    check_eq("stream_pops", pops - p0, 20);
    idle(3);

    // Illegal saturation.
    for (int i = 0; i < 300; i++) begin
      push_op(2'b10, 6'b000000, $urandom, $urandom);
    end
    idle(3);
    check_eq("ill_sat_cnt", illegal_cnt_o, 8'd255);
    out_ready_i = 1'b0;
    push_op(2'b10, 6'b000000, 32'd9, 32'd9);
    check_eq("ill_flag", illegal_o, 1);
    check_eq("ill_ctrl", ALUControl_o, 3'b000);
    out_ready_i = 1'b1;
    idle(3);

    // Multiply encoding depends on configuration.
    out_ready_i = 1'b0;
    push_op(2'b10, 6'b011000, 32'd6, 32'd7);
`ifdef ALU_ISSUE_MUL_EN
    check_eq("mul_ctrl", ALUControl_o, 3'b100);
    check_eq("mul_flag", illegal_o, 0);
`else
    check_eq("mul_ctrl", ALUControl_o, 3'b000);
    check_eq("mul_flag", illegal_o, 1);
`endif
    out_ready_i = 1'b1;
    idle(3);

    // Reset with two entries held.
    out_ready_i = 1'b0;
    push_op(2'b00, 6'h00, 32'hAA, 32'hBB);
    push_op(2'b10, 6'h00, 32'hCC, 32'hDD);
    rst_i = 1'b0;
    #1;
    check_eq("mid_rst_valid", out_valid_o, 0);
    check_eq("mid_rst_ready", in_ready_o, 0);
    check_eq("mid_rst_d1", data1_o, 0);
    check_eq("mid_rst_d2", data2_o, 0);
    check_eq("mid_rst_ctrl", ALUControl_o, 0);
    check_eq("mid_rst_ill", illegal_o, 0);
    check_eq("mid_rst_cnt", illegal_cnt_o, 0);
    idle(3);
    rst_i = 1'b1;
    out_ready_i = 1'b1;
    p0 = pops;
    idle(5);
    check_eq("post_rst_no_pop", pops, p0);
    push_op(2'b01, 6'h00, 32'd40, 32'd2);
    idle(2);
    check_eq("post_rst_pop", pops, p0 + 1);
    check_eq("final_drain", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
